cordic_vec_iter: RTL and testbench

Iterative CORDIC vectoring engine: one shared 12-bit micro-rotation datapath, sequenced over ITER cycles by an internal FSM and iteration counter, with a per-iteration arctangent ROM. It replaces a fully unrolled stage chain when area matters more than throughput. Valid/ready handshakes on both sides let it sit between an operand source and a magnitude/phase consumer.

---
 rtl/cordic_vec_iter.sv | 119 +++++++++++
 tb/tb_cordic_vec_iter.sv | 309 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/cordic_vec_iter.sv
// Iterative CORDIC vectoring engine: a single shared micro-rotation datapath
// sequenced over ITER cycles, with valid/ready handshakes on both sides.
module cordic_vec_iter #(
  parameter int unsigned ITER = 12
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic signed [11:0]  x_in,
  input  logic signed [11:0]  y_in,
  input  logic signed [11:0]  theta_in,
  output logic                out_valid,
  input  logic                out_ready,
  output logic signed [11:0]  x_out,
  output logic signed [11:0]  y_out,
  output logic signed [11:0]  theta_out,
  output logic                busy
);

  localparam int unsigned W  = 12;
  localparam int unsigned CW = 4;

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_RUN  = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  logic [1:0]          state, state_nxt;
  logic [CW-1:0]       cnt, cnt_nxt;
  logic signed [W-1:0] x, y, z;
  logic signed [W-1:0] x_nxt, y_nxt, z_nxt;
  logic signed [W-1:0] xs, ys, at;

  // Per-iteration arctangent in 2^-10 rad
  function automatic logic signed [W-1:0] atan_rom(input logic [CW-1:0] i);
    case (i)
      4'd0:    atan_rom = 12'sd804;
      4'd1:    atan_rom = 12'sd475;
      4'd2:    atan_rom = 12'sd251;
      4'd3:    atan_rom = 12'sd127;
      4'd4:    atan_rom = 12'sd64;
      4'd5:    atan_rom = 12'sd32;
      4'd6:    atan_rom = 12'sd16;
      4'd7:    atan_rom = 12'sd8;
      4'd8:    atan_rom = 12'sd4;
      4'd9:    atan_rom = 12'sd2;
      4'd10:   atan_rom = 12'sd1;
      default: atan_rom = 12'sd0;
    endcase
  endfunction

  // Next-state and datapath update; both rotations read the pre-update x/y
  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    x_nxt     = x;
    y_nxt     = y;
    z_nxt     = z;
    xs        = x >>> cnt;
    ys        = y >>> cnt;
    at        = atan_rom(cnt);
    case (state)
      S_IDLE: begin
        if (in_valid) begin
          x_nxt     = x_in;
          y_nxt     = y_in;
          z_nxt     = theta_in;
          cnt_nxt   = '0;
          state_nxt = S_RUN;
        end
      end
      S_RUN: begin
        if (!y[W-1]) begin
          x_nxt = x + ys;
          y_nxt = y - xs;
          z_nxt = z + at;
        end else begin
          x_nxt = x - ys;
          y_nxt = y + xs;
          z_nxt = z - at;
        end
        cnt_nxt = cnt + CW'(1);
        if (cnt == CW'(ITER - 1)) state_nxt = S_DONE;
      end
      S_DONE: begin
        if (out_ready) state_nxt = S_IDLE;
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  // State, datapath and registered status flags
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= S_IDLE;
      cnt       <= '0;
      x         <= '0;
      y         <= '0;
      z         <= '0;
      in_ready  <= 1'b1;
      out_valid <= 1'b0;
      busy      <= 1'b0;
    end else begin
      state     <= state_nxt;
      cnt       <= cnt_nxt;
      x         <= x_nxt;
      y         <= y_nxt;
      z         <= z_nxt;
      in_ready  <= (state_nxt == S_IDLE);
      out_valid <= (state_nxt == S_DONE);
      busy      <= (state_nxt != S_IDLE);
    end
  end

  assign x_out     = x;
  assign y_out     = y;
  assign theta_out = z;

endmodule

// File: tb/tb_cordic_vec_iter.sv
// Self-checking bench for cordic_vec_iter: directed vectors, backpressure,
// reset abort, back-to-back spacing and randomized operands vs a reference model.
module tb_cordic_vec_iter;

  logic clk = 1'b0;
  logic rst;
  logic in_valid, in_ready, out_valid, out_ready, busy;
  logic signed [11:0] x_in, y_in, theta_in, x_out, y_out, theta_out;

  logic in_valid6, in_ready6, out_valid6, out_ready6, busy6;
  logic signed [11:0] x_in6, y_in6, theta_in6, x_out6, y_out6, theta_out6;

  int passed = 0;
  int total  = 0;

  always #5 clk = ~clk;

  cordic_vec_iter #(.ITER(12)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready),
    .x_in(x_in), .y_in(y_in), .theta_in(theta_in),
    .out_valid(out_valid), .out_ready(out_ready),
    .x_out(x_out), .y_out(y_out), .theta_out(theta_out),
    .busy(busy)
  );

  cordic_vec_iter #(.ITER(6)) dut6 (
    .clk(clk), .rst(rst),
    .in_valid(in_valid6), .in_ready(in_ready6),
    .x_in(x_in6), .y_in(y_in6), .theta_in(theta_in6),
    .out_valid(out_valid6), .out_ready(out_ready6),
    .x_out(x_out6), .y_out(y_out6), .theta_out(theta_out6),
    .busy(busy6)
  );

  // Reference model: 12-bit wrapping vectoring rotation in plain integer arithmetic
  function automatic int wrap12(input int v);
    logic [11:0] t;
    t = 12'(v);
    return int'($signed(t));
  endfunction

  function automatic int floor_div(input int v, input int d);
    int q;
    q = v / d;
    if ((v % d != 0) && (v < 0)) q = q - 1;
    return q;
  endfunction

  function automatic int iabs(input int v);
    return (v < 0) ? -v : v;
  endfunction

  function automatic void model(input int xi, input int yi, input int zi, input int n,
                                output int xo, output int yo, output int zo);
    int atan_tab[12] = '{804, 475, 251, 127, 64, 32, 16, 8, 4, 2, 1, 0};
    int xv, yv, zv, dx, dy;
    xv = wrap12(xi);
    yv = wrap12(yi);
    zv = wrap12(zi);
    for (int i = 0; i < n; i++) begin
      dx = floor_div(xv, 1 << i);
      dy = floor_div(yv, 1 << i);
      if (yv >= 0) begin
        xv = wrap12(xv + dy); yv = wrap12(yv - dx); zv = wrap12(zv + atan_tab[i]);
      end else begin
        xv = wrap12(xv - dy); yv = wrap12(yv + dx); zv = wrap12(zv - atan_tab[i]);
      end
    end
    xo = xv; yo = yv; zo = zv;
  endfunction

  // Present one operand, then count edges (accept edge = 1) until out_valid
  task automatic run_op(input int xi, input int yi, input int zi, output int lat);
    @(negedge clk);
    x_in = 12'(xi); y_in = 12'(yi); theta_in = 12'(zi);
    in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    lat = 1;
    while (out_valid !== 1'b1 && lat < 40) begin
      @(posedge clk); #1;
      lat++;
    end
  endtask

  task automatic release_result();
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    total++; if (in_ready !== 1'b1) $display("FAIL reset_in_ready: got %b expected 1", in_ready); else passed++;
    total++; if (out_valid !== 1'b0) $display("FAIL reset_out_valid: got %b expected 0", out_valid); else passed++;
    total++; if (busy !== 1'b0) $display("FAIL reset_busy: got %b expected 0", busy); else passed++;
    total++; if ({x_out, y_out, theta_out} !== 36'd0)
      $display("FAIL reset_outputs: got %0d/%0d/%0d expected 0/0/0", x_out, y_out, theta_out); else passed++;
    total++; if (in_ready6 !== 1'b1) $display("FAIL reset_in_ready6: got %b expected 1", in_ready6); else passed++;
  endtask

  task automatic test_vectors();
    int vx[3] = '{600, 700, 1000};
    int vy[3] = '{-800, 700, 0};
    int vz[3] = '{0, 100, 0};
    int ax[3] = '{1647, 1630, 1647};
    int az[3] = '{-950, 904, 0};
    int lat, ex, ey, ez;
    for (int k = 0; k < 3; k++) begin
      run_op(vx[k], vy[k], vz[k], lat);
      model(vx[k], vy[k], vz[k], 12, ex, ey, ez);
      total++; if (lat !== 13) $display("FAIL vec%0d_latency: got %0d expected 13", k, lat); else passed++;
      total++; if (int'(x_out) !== ex) $display("FAIL vec%0d_x: got %0d expected %0d", k, x_out, ex); else passed++;
      total++; if (int'(y_out) !== ey) $display("FAIL vec%0d_y: got %0d expected %0d", k, y_out, ey); else passed++;
      total++; if (int'(theta_out) !== ez) $display("FAIL vec%0d_theta: got %0d expected %0d", k, theta_out, ez); else passed++;
      total++; if ((iabs(int'(x_out) - ax[k]) <= 6) !== 1'b1)
        $display("FAIL vec%0d_mag_approx: got %0d expected %0d+-6", k, x_out, ax[k]); else passed++;
      total++; if ((iabs(int'(theta_out) - az[k]) <= 4) !== 1'b1)
        $display("FAIL vec%0d_angle_approx: got %0d expected %0d+-4", k, theta_out, az[k]); else passed++;
      total++; if ((iabs(int'(y_out)) <= 4) !== 1'b1)
        $display("FAIL vec%0d_resid_y: got %0d expected |y|<=4", k, y_out); else passed++;
      release_result();
      total++; if ({out_valid, in_ready} !== 2'b01)
        $display("FAIL vec%0d_release: got valid/ready %b%b expected 01", k, out_valid, in_ready); else passed++;
    end
  endtask

  // y = 0 must take the positive branch on the first micro-rotation
  task automatic test_zero_branch();
    int n;
    @(negedge clk);
    x_in = 12'sd1000; y_in = 12'sd0; theta_in = 12'sd0;
    in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    @(posedge clk); #1;
    total++; if ({int'(x_out), int'(y_out), int'(theta_out)} !== {32'sd1000, -32'sd1000, 32'sd804})
      $display("FAIL zero_branch_step0: got %0d/%0d/%0d expected 1000/-1000/804", x_out, y_out, theta_out); else passed++;
    n = 0;
    while (out_valid !== 1'b1 && n < 40) begin @(posedge clk); #1; n++; end
    total++; if (out_valid !== 1'b1) $display("FAIL zero_branch_done: got %b expected 1", out_valid); else passed++;
    release_result();
  endtask

  task automatic test_backpressure();
    int lat, ex, ey, ez, n;
    run_op(500, 300, 50, lat);
    model(500, 300, 50, 12, ex, ey, ez);
    total++; if (lat !== 13) $display("FAIL bp_latency: got %0d expected 13", lat); else passed++;
    @(negedge clk);
    x_in = 12'sd111; y_in = 12'sd222; theta_in = -12'sd33;
    in_valid = 1'b1;
    for (int c = 0; c < 5; c++) begin
      @(posedge clk); #1;
      total++; if ({int'(x_out), int'(y_out), int'(theta_out)} !== {ex, ey, ez})
        $display("FAIL bp_hold%0d: got %0d/%0d/%0d expected %0d/%0d/%0d", c, x_out, y_out, theta_out, ex, ey, ez); else passed++;
      total++; if ({out_valid, in_ready, busy} !== 3'b101)
        $display("FAIL bp_flags%0d: got valid/ready/busy %b%b%b expected 101", c, out_valid, in_ready, busy); else passed++;
    end
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    total++; if ({out_valid, in_ready} !== 2'b01)
      $display("FAIL bp_release: got valid/ready %b%b expected 01", out_valid, in_ready); else passed++;
    @(posedge clk); #1;
    in_valid = 1'b0;
    total++; if ({busy, in_ready, int'(x_out), int'(y_out), int'(theta_out)} !== {1'b1, 1'b0, 32'sd111, 32'sd222, -32'sd33})
      $display("FAIL bp_next_accept: got busy %b ready %b x/y/z %0d/%0d/%0d expected busy 1 ready 0 111/222/-33",
               busy, in_ready, x_out, y_out, theta_out); else passed++;
    model(111, 222, -33, 12, ex, ey, ez);
    n = 1;
    while (out_valid !== 1'b1 && n < 40) begin @(posedge clk); #1; n++; end
    total++; if ({n, int'(x_out), int'(y_out), int'(theta_out)} !== {32'sd13, ex, ey, ez})
      $display("FAIL bp_second_result: got lat %0d %0d/%0d/%0d expected 13 %0d/%0d/%0d",
               n, x_out, y_out, theta_out, ex, ey, ez); else passed++;
    release_result();
  endtask

  task automatic test_reset_mid_run();
    int seen, lat;
    @(negedge clk);
    x_in = 12'sd600; y_in = -12'sd800; theta_in = 12'sd0;
    in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (3) begin @(posedge clk); #1; end
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    total++; if ({in_ready, busy, out_valid, x_out, y_out, theta_out} !== {3'b100, 36'd0})
      $display("FAIL rst_run_state: got ready/busy/valid %b%b%b x/y/z %0d/%0d/%0d expected 100 0/0/0",
               in_ready, busy, out_valid, x_out, y_out, theta_out); else passed++;
    seen = 0;
    for (int c = 0; c < 20; c++) begin
      @(posedge clk); #1;
      if (out_valid === 1'b1) seen++;
    end
    total++; if (seen !== 0) $display("FAIL rst_run_no_valid: got %0d pulses expected 0", seen); else passed++;
    run_op(300, 200, 10, lat);
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    total++; if ({out_valid, in_ready, x_out, y_out, theta_out} !== {2'b01, 36'd0})
      $display("FAIL rst_done_state: got valid/ready %b%b x/y/z %0d/%0d/%0d expected 01 0/0/0",
               out_valid, in_ready, x_out, y_out, theta_out); else passed++;
  endtask

  task automatic test_random();
    int xi, yi, zi, lat, ex, ey, ez, errs;
    errs = 0;
    for (int n = 0; n < 30; n++) begin
      if (n < 20) begin
        do begin
          xi = int'($urandom_range(0, 1200));
          yi = int'($urandom_range(0, 2400)) - 1200;
        end while (xi * xi + yi * yi > 1440000);
        zi = int'($urandom_range(0, 1000)) - 500;
      end else begin
        xi = int'($urandom_range(0, 4095)) - 2048;
        yi = int'($urandom_range(0, 4095)) - 2048;
        zi = int'($urandom_range(0, 4095)) - 2048;
      end
      out_ready = n[0];
      run_op(xi, yi, zi, lat);
      model(xi, yi, zi, 12, ex, ey, ez);
      total++; if ({lat, int'(x_out), int'(y_out), int'(theta_out)} !== {32'sd13, ex, ey, ez}) begin
        $display("FAIL rand%0d (%0d,%0d,%0d): got lat %0d %0d/%0d/%0d expected 13 %0d/%0d/%0d",
                 n, xi, yi, zi, lat, x_out, y_out, theta_out, ex, ey, ez);
        errs++;
      end else passed++;
      if (n[0]) begin
        @(posedge clk); #1;
        out_ready = 1'b0;
        total++; if ({out_valid, in_ready} !== 2'b01)
          $display("FAIL rand%0d_one_cycle_valid: got valid/ready %b%b expected 01", n, out_valid, in_ready); else passed++;
      end else begin
        release_result();
      end
    end
  endtask

  task automatic test_back_to_back();
    int rises[$];
    logic prev;
    in_valid = 1'b1; out_ready = 1'b1;
    x_in = 12'sd300; y_in = 12'sd400; theta_in = 12'sd0;
    prev = busy;
    for (int c = 0; c < 40; c++) begin
      @(posedge clk); #1;
      if (busy === 1'b1 && prev !== 1'b1) rises.push_back(c);
      prev = busy;
    end
    in_valid = 1'b0;
    total++; if (rises.size() !== 3) $display("FAIL b2b_accepts: got %0d expected 3", rises.size()); else passed++;
    if (rises.size() >= 3) begin
      total++; if ((rises[1] - rises[0]) !== 14) $display("FAIL b2b_spacing0: got %0d expected 14", rises[1] - rises[0]); else passed++;
      total++; if ((rises[2] - rises[1]) !== 14) $display("FAIL b2b_spacing1: got %0d expected 14", rises[2] - rises[1]); else passed++;
    end
    repeat (20) @(posedge clk);
    #1 out_ready = 1'b0;
    total++; if ({busy, in_ready} !== 2'b01) $display("FAIL b2b_idle: got busy/ready %b%b expected 01", busy, in_ready); else passed++;
  endtask

  task automatic test_iter6();
    int lat, ex, ey, ez;
    @(negedge clk);
    x_in6 = 12'sd600; y_in6 = -12'sd800; theta_in6 = 12'sd0;
    in_valid6 = 1'b1;
    @(posedge clk); #1;
    in_valid6 = 1'b0;
    lat = 1;
    while (out_valid6 !== 1'b1 && lat < 40) begin @(posedge clk); #1; lat++; end
    model(600, -800, 0, 6, ex, ey, ez);
    total++; if (lat !== 7) $display("FAIL iter6_latency: got %0d expected 7", lat); else passed++;
    total++; if ({int'(x_out6), int'(y_out6), int'(theta_out6)} !== {ex, ey, ez})
      $display("FAIL iter6_result: got %0d/%0d/%0d expected %0d/%0d/%0d", x_out6, y_out6, theta_out6, ex, ey, ez); else passed++;
    total++; if ((iabs(int'(theta_out6) + 950) <= 32) !== 1'b1)
      $display("FAIL iter6_angle_approx: got %0d expected -950+-32", theta_out6); else passed++;
    out_ready6 = 1'b1;
    @(posedge clk); #1;
    out_ready6 = 1'b0;
    total++; if ({out_valid6, in_ready6} !== 2'b01)
      $display("FAIL iter6_release: got valid/ready %b%b expected 01", out_valid6, in_ready6); else passed++;
  endtask

  initial begin
    rst = 1'b1;
    in_valid = 1'b0; out_ready = 1'b0;
    x_in = '0; y_in = '0; theta_in = '0;
    in_valid6 = 1'b0; out_ready6 = 1'b0;
    x_in6 = '0; y_in6 = '0; theta_in6 = '0;
    test_reset();
    test_vectors();
    test_zero_branch();
    test_backpressure();
    test_reset_mid_run();
    test_random();
    test_back_to_back();
    test_iter6();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
